// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline control block.
package pipeline_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Instruction encodings the controller cares about.
  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;

  // Width of the drain counter.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a register that the
// load currently in EX has not yet written. x0 never creates a hazard.
module load_use_detect (
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] rd_addr,
  input  logic       is_load,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = uses_rs1 && (rs1_addr == rd_addr);
  assign rs2_match = uses_rs2 && (rs2_addr == rd_addr);
  assign hazard    = is_load && (rd_addr != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing control: load-use stalls, taken-branch squash and ebreak drain/halt.
// Optional build macro PIPELINE_CTRL_PERF_EN adds saturating stall/flush event counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic [31:0] if_instr,
  output logic        pc_en,
  output logic        pc_sel_branch,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_CYCLES);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .rd_addr  (ex_rd_addr),
    .is_load  (ex_is_load),
    .hazard   (hazard)
  );

  // Next-state and zero-latency output decode from current state and inputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    halted        = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            // Wrong-path hazard or ebreak is discarded with the squash.
            pc_sel_branch = 1'b1;
            pc_en         = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
          end else if (hazard) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            if (if_instr == EBREAK_INSTR) begin
              cnt_d   = DrainLoad;
              state_d = (DrainLoad <= CNT_W'(1)) ? HALTED : DRAIN;
            end
          end
        end
        DRAIN: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (ex_branch_taken) begin
            // An older branch proves the ebreak was wrong-path: resume.
            pc_sel_branch = 1'b1;
            pc_en         = 1'b1;
            state_d       = RUN;
            cnt_d         = '0;
          end else begin
            if (cnt_q > CNT_W'(1)) cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(2)) state_d = HALTED;
          end
        end
        HALTED: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_d     = RUN;
          cnt_d       = '0;
        end
      endcase
    end
  end

  // State and drain counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic stall_cyc;
  logic flush_cyc;

  assign stall_cyc = !rst && (state_q == RUN) && !ex_branch_taken && hazard;
  assign flush_cyc = !rst && ex_branch_taken && ((state_q == RUN) || (state_q == DRAIN));

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_cyc && (stall_count != 32'hFFFFFFFF)) stall_count <= stall_count + 32'd1;
      if (flush_cyc && (flush_count != 32'hFFFFFFFF)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a stimulus task computes expected controls from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int unsigned D = 4;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1_addr = '0;
  logic [4:0]  id_rs2_addr = '0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_is_load = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic [31:0] if_instr = NOP;
  logic        pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush, halted;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.DRAIN_CYCLES(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd_addr      (ex_rd_addr),
    .ex_is_load      (ex_is_load),
    .ex_branch_taken (ex_branch_taken),
    .if_instr        (if_instr),
    .pc_en           (pc_en),
    .pc_sel_branch   (pc_sel_branch),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .halted          (halted)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  // ctl = {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush, halted}
  typedef struct packed {
    logic        chk_cnt;
    logic [5:0]  ctl;
    logic [31:0] stalls;
    logic [31:0] flushes;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;

  // Behavioural model: remaining drain cycles before halt, halted flag, event totals.
  int          drain_left = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                      input logic br, input logic [31:0] ins);
    exp_t e;
    bit   hz;
    @(posedge clk);
    #1;
    rst = r; id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd_addr = rd; ex_is_load = ld; ex_branch_taken = br; if_instr = ins;
    hz = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e.chk_cnt = !r;
    e.stalls  = m_stalls;
    e.flushes = m_flushes;
    if (r) begin
      e.ctl = 6'b000110;
      drain_left = 0; m_halted = 1'b0; m_stalls = '0; m_flushes = '0;
    end else if (m_halted) begin
      e.ctl = 6'b000111;
    end else if (drain_left > 0) begin
      if (br) begin
        e.ctl = 6'b110110;
        drain_left = 0;
        m_flushes = sat_inc(m_flushes);
      end else begin
        e.ctl = 6'b000110;
        drain_left--;
        if (drain_left == 0) m_halted = 1'b1;
      end
    end else if (br) begin
      e.ctl = 6'b110110;
      m_flushes = sat_inc(m_flushes);
    end else if (hz) begin
      e.ctl = 6'b000010;
      m_stalls = sat_inc(m_stalls);
    end else begin
      e.ctl = 6'b101000;
      if (ins == EBREAK) begin
        if (D == 1) m_halted = 1'b1;
        else drain_left = D - 1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, NOP);
  endtask

  // Monitor: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush, halted} !== mon_e.ctl) begin
        failures++;
        $display("FAIL ctl t=%0t got=%b exp=%b", $time,
                 {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush, halted}, mon_e.ctl);
      end
`ifdef PIPELINE_CTRL_PERF_EN
      if (mon_e.chk_cnt) begin
        checks += 2;
        if (stall_count !== mon_e.stalls) begin
          failures++;
          $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, mon_e.stalls);
        end
        if (flush_count !== mon_e.flushes) begin
          failures++;
          $display("FAIL flush_count t=%0t got=%0d exp=%0d", $time, flush_count, mon_e.flushes);
        end
      end
`endif
    end
  end

  initial begin
    logic        r, br, ld, u1, u2;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ins;
    // Reset
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NOP);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NOP);
    idle(2);
    // Load x5 in EX, ID reads x5 via rs1; then via rs2
    step(1'b0, 5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, NOP);
    idle(1);
    step(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, NOP);
    idle(1);
    // Matching address but operand unused, and load to x0: no stall
    step(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, NOP);
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, NOP);
    // Taken branch with simultaneous hazard and ebreak
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, EBREAK);
    idle(1);
    // Stalled ebreak is not captured
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, EBREAK);
    idle(2);
    // ebreak: drain then halt, hold through branch and further ebreak
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, EBREAK);
    idle(5);
    step(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, EBREAK);
    idle(1);
    // Reset in HALTED
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NOP);
    idle(2);
    // ebreak aborted by branch in second DRAIN cycle
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, EBREAK);
    idle(1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, NOP);
    idle(6);
    // Reset mid-DRAIN
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, EBREAK);
    idle(1);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, NOP);
    idle(5);
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 5) == 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      ld  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 5) == 0);
      ins = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom();
      step(r, rs1, rs2, u1, u2, rd, ld, br, ins);
    end
    // Let the monitor drain the scoreboard, bounded
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central control block for the five-stage RISC-V pipelined datapath. It sequences the fetch/decode/execute pipeline registers: it inserts a one-cycle bubble on load-use hazards and squashes wrong-path instructions on taken branches. It also drains and halts the pipeline when `ebreak` (32'h00100073) is fetched. It sits beside the datapath and drives the enable and flush inputs of the PC, `if_id` and `id_ex` registers. The halt logic replaces the ad-hoc `broken` flag in fetch.

## Interface
Parameters:
- DRAIN_CYCLES, 4, cycles to wait after `ebreak` enters ID before asserting `halted`; range 1..15.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- id_rs1_addr  input  5  rs1 of the instruction in ID
- id_rs2_addr  input  5  rs2 of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_rd_addr  input  5  destination register of the instruction in EX
- ex_is_load  input  1  EX instruction is a load
- ex_branch_taken  input  1  EX branch/jump resolved taken this cycle
- if_instr  input  32  instruction word currently in IF
- pc_en  output  1  PC may advance
- pc_sel_branch  output  1  PC loads the branch target instead of pc+4
- if_id_en  output  1  `if_id` captures a new instruction
- if_id_flush  output  1  `if_id` loads a NOP
- id_ex_flush  output  1  `id_ex` loads a bubble
- halted  output  1  pipeline drained and stopped

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Load-use hazard: `ex_is_load && ex_rd_addr != 0 && ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr))`.
- RUN, priority order:
  - Taken branch: pc_sel_branch=1, pc_en=1, if_id_flush=1, id_ex_flush=1. A simultaneous load-use hazard or IF `ebreak` is ignored, because it is on the wrong path.
  - Load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, for one cycle. An IF `ebreak` is not captured while stalled.
  - Otherwise pc_en=1, if_id_en=1. If if_instr == EBREAK, go to DRAIN and load drain counter = DRAIN_CYCLES.
- DRAIN:
  - pc_en=0, if_id_flush=1, id_ex_flush=1. The `ebreak` becomes a NOP, and older instructions retire.
  - The counter decrements each cycle. Go to HALTED when it reaches 1.
  - If ex_branch_taken arrives in DRAIN (an older branch means `ebreak` was wrong-path): abort, apply the taken-branch outputs, return to RUN, and clear the counter.
- HALTED: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=1. Only rst leaves HALTED.
- Counter width is 4 bits and never wraps. It decrements only in DRAIN.

## Timing
- State and drain counter are registered. All control outputs are combinational from the current state and the current-cycle inputs, with zero latency.
- While rst=1: pc_en=0, pc_sel_branch=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=0.
- First cycle after rst deasserts: RUN, pc_en=1.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge, and the counter clears.
- `ebreak` fetched at edge N: DRAIN from N+1; halted=1 from N+1+DRAIN_CYCLES-1.
- Load-use stall lasts exactly one cycle. The next cycle the load is in MEM, and the existing forwarding path supplies the value.

## Configuration
- PIPELINE_CTRL_PERF_EN defined: adds outputs `stall_count` [31:0] and `flush_count` [31:0].
  - `stall_count` increments on each load-use stall cycle.
  - `flush_count` increments on each taken-branch cycle in RUN or DRAIN.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Package `pipeline_pkg`: state enum `ctrl_state_t` {RUN, DRAIN, HALTED}, constant `EBREAK_INSTR = 32'h00100073`, constant `NOP_INSTR = 32'h00000013`.
- One combinational sub-module, `load_use_detect`: address compare producing the hazard bit.
- The FSM, counter and output decode live in `pipeline_ctrl`.

## Test plan
- Load x5 in EX, ID reads rs1=x5 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; next cycle pc_en=1.
- Load with rd=x0 in EX, ID reads x0 -> no stall.
- ex_branch_taken=1 with a simultaneous load-use hazard -> pc_sel_branch=1, both flushes=1, pc_en=1; no stall cycle follows.
- if_instr=32'h00100073 with DRAIN_CYCLES=4 -> DRAIN for 3 cycles, halted=1 on the 4th; outputs hold until rst.
- `ebreak` fetched, then ex_branch_taken=1 in the second DRAIN cycle -> back to RUN, pc_sel_branch=1, halted never asserts.
- rst asserted in HALTED -> next cycle RUN, halted=0, pc_en=1; with PIPELINE_CTRL_PERF_EN, both counters read 0.
